// File: rtl/convo_fifo_pmul_if.sv
// Bus bundle between the raster pixel source/consumer and convo_fifo_pmul.
//
// Handshake semantics:
//   ff_wen is a write strobe. The write is accepted at a rising edge when
//   ff_full is low before that edge. Otherwise the write is dropped.
//   ff_ren is a window-advance strobe. The read is accepted at a rising edge
//   when ff_load_done is high before that edge. Otherwise it is ignored.
//   An accepted read presents its window and entry one cycle later, marked by
//   a one-cycle entry_vld pulse.
//
// Signals:
//   ff_ren, ff_wen    strobes (master -> slave)
//   ff_row_len        row length L in pixels (master -> slave)
//   ff_stride         horizontal stride S; 0 behaves as 1 (master -> slave)
//   ff_din            write pixel (master -> slave)
//   ff_out2/1/0       window top/middle/bottom row, column 0 in the low slice
//   ff_load_done      a full 3x3 window is stored
//   ff_empty, ff_full, ff_cnt   occupancy
//   entry, entry_vld  window centre pixel and its update pulse
interface convo_fifo_pmul_if #(
    parameter int FF_WIDTH    = 8,
    parameter int FF_ADDR_BIT = 10
);
    logic                     ff_ren;
    logic                     ff_wen;
    logic [FF_ADDR_BIT:0]     ff_row_len;
    logic [2:0]               ff_stride;
    logic [FF_WIDTH-1:0]      ff_din;
    logic [3*FF_WIDTH-1:0]    ff_out2;
    logic [3*FF_WIDTH-1:0]    ff_out1;
    logic [3*FF_WIDTH-1:0]    ff_out0;
    logic                     ff_load_done;
    logic                     ff_empty;
    logic                     ff_full;
    logic [FF_ADDR_BIT:0]     ff_cnt;
    logic [FF_WIDTH-1:0]      entry;
    logic                     entry_vld;

    modport master (
        output ff_ren, ff_wen, ff_row_len, ff_stride, ff_din,
        input  ff_out2, ff_out1, ff_out0, ff_load_done, ff_empty, ff_full,
               ff_cnt, entry, entry_vld
    );

    modport slave (
        input  ff_ren, ff_wen, ff_row_len, ff_stride, ff_din,
        output ff_out2, ff_out1, ff_out0, ff_load_done, ff_empty, ff_full,
               ff_cnt, entry, entry_vld
    );
endinterface

// File: rtl/convo_fifo_pmul.sv
// Raster-order pixel FIFO feeding a 3x3 convolution engine.
// Pixels are written one per cycle. Each accepted read registers the 3x3
// window starting at the head pointer, along with its centre pixel for the
// pointwise-multiply path. The head then advances by the stride, or jumps to
// the start of the next row when another window no longer fits in the row.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  convo_fifo_pmul_if slave modport (strobes, config, window outputs)
module convo_fifo_pmul #(
    parameter int FF_WIDTH    = 8,
    parameter int FF_ADDR_BIT = 10
) (
    input  logic               clk,
    input  logic               rst,
    convo_fifo_pmul_if.slave   bus
);
    localparam int A = FF_ADDR_BIT;
    localparam int W = FF_WIDTH;
    localparam int D = 1 << A;

    logic [W-1:0]   mem [D];
    logic [A-1:0]   wp;
    logic [A-1:0]   hp;
    logic [A:0]     cnt;
    logic [A:0]     col;

    logic [A:0]     row_len;
    logic [2:0]     stride_eff;
    logic [A+2:0]   need;
    logic           load_done;
    logic           wr_acc;
    logic           rd_acc;
    logic [A-1:0]   off_l;
    logic [A-1:0]   off_2l;
    logic [3*W-1:0] row_top;
    logic [3*W-1:0] row_mid;
    logic [3*W-1:0] row_bot;
    logic [W-1:0]   centre;
    logic [A+1:0]   fit;
    logic [A:0]     pop_raw;
    logic [A:0]     pop;
    logic [A:0]     col_next;
    logic [A:0]     cnt_next;

    assign row_len    = bus.ff_row_len;
    assign stride_eff = (bus.ff_stride == 3'd0) ? 3'd1 : bus.ff_stride;

    // 2L+3 needs two extra bits so that it cannot wrap for any L.
    assign need      = {1'b0, row_len, 1'b0} + (A+3)'(3);
    assign load_done = ({2'b00, cnt} >= need);

    assign wr_acc = bus.ff_wen && (cnt < (A+1)'(D));
    assign rd_acc = bus.ff_ren && load_done;

    // Row offsets modulo D.
    assign off_l  = row_len[A-1:0];
    assign off_2l = off_l << 1;

    always_comb begin
        row_top = '0;
        row_mid = '0;
        row_bot = '0;
        for (int k = 0; k < 3; k++) begin
            row_top[k*W +: W] = mem[hp + A'(k)];
            row_mid[k*W +: W] = mem[hp + off_l + A'(k)];
            row_bot[k*W +: W] = mem[hp + off_2l + A'(k)];
        end
        centre = mem[hp + off_l + A'(1)];
    end

    // Pop amount: step by the stride while a full window still fits in the
    // row. Otherwise, discard the rest of the row. A column left beyond L by
    // a configuration change would make L-col wrap. Clamping to cnt keeps
    // the counter sane in that case.
    always_comb begin
        fit      = {1'b0, col} + (A+2)'(stride_eff) + (A+2)'(3);
        pop_raw  = '0;
        col_next = '0;
        if (fit <= {1'b0, row_len}) begin
            pop_raw  = (A+1)'(stride_eff);
            col_next = col + (A+1)'(stride_eff);
        end else begin
            pop_raw  = row_len - col;
            col_next = '0;
        end
        pop = (pop_raw > cnt) ? cnt : pop_raw;
    end

    always_comb begin
        cnt_next = cnt;
        if (wr_acc) cnt_next = cnt_next + (A+1)'(1);
        if (rd_acc) cnt_next = cnt_next - pop;
    end

    // Storage is not reset; the pointers and the counter define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wp] <= bus.ff_din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp            <= '0;
            hp            <= '0;
            cnt           <= '0;
            col           <= '0;
            bus.ff_out2   <= '0;
            bus.ff_out1   <= '0;
            bus.ff_out0   <= '0;
            bus.entry     <= '0;
            bus.entry_vld <= 1'b0;
        end else begin
            cnt           <= cnt_next;
            bus.entry_vld <= rd_acc;
            if (wr_acc) wp <= wp + A'(1);
            if (rd_acc) begin
                bus.ff_out2 <= row_top;
                bus.ff_out1 <= row_mid;
                bus.ff_out0 <= row_bot;
                bus.entry   <= centre;
                hp          <= hp + pop[A-1:0];
                col         <= col_next;
            end
        end
    end

    assign bus.ff_load_done = load_done;
    assign bus.ff_empty     = (cnt == '0);
    assign bus.ff_full      = (cnt == (A+1)'(D));
    assign bus.ff_cnt       = cnt;
endmodule

// File: tb/tb_convo_fifo_pmul.sv
module tb_convo_fifo_pmul;
    localparam int W = 8;
    localparam int A = 10;
    localparam int D = 1 << A;

    logic clk = 1'b0;
    logic rst = 1'b0;

    convo_fifo_pmul_if #(.FF_WIDTH(W), .FF_ADDR_BIT(A)) bus ();

    convo_fifo_pmul #(.FF_WIDTH(W), .FF_ADDR_BIT(A)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    // Stored pixels in arrival order; exp_q[0] is the window's top-left pixel.
    logic [W-1:0]   exp_q[$];
    int             m_col;
    int             m_l;
    int             m_s;
    logic [3*W-1:0] m_out2, m_out1, m_out0;
    logic [W-1:0]   m_entry;
    logic           m_vld;

    task automatic model_reset();
        exp_q.delete();
        m_col   = 0;
        m_out2  = '0;
        m_out1  = '0;
        m_out0  = '0;
        m_entry = '0;
        m_vld   = 1'b0;
    endtask

    // Applies one clock edge to the model, based on the pre-edge state.
    task automatic model_edge(input bit ren, input bit wen, input logic [W-1:0] din);
        int n, s, p;
        n = exp_q.size();
        s = (m_s == 0) ? 1 : m_s;
        if (ren && n >= 2*m_l + 3) begin
            for (int k = 0; k < 3; k++) begin
                m_out2[k*W +: W] = exp_q[k];
                m_out1[k*W +: W] = exp_q[m_l + k];
                m_out0[k*W +: W] = exp_q[2*m_l + k];
            end
            m_entry = exp_q[m_l + 1];
            m_vld   = 1'b1;
            if (m_col + s + 3 <= m_l) begin
                p     = s;
                m_col = m_col + s;
            end else begin
                p     = m_l - m_col;
                m_col = 0;
            end
            for (int k = 0; k < p; k++) void'(exp_q.pop_front());
        end else begin
            m_vld = 1'b0;
        end
        if (wen && n < D) exp_q.push_back(din);
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b0;
        bus.ff_ren  = 1'b0;
        bus.ff_wen  = 1'b0;
        bus.ff_din  = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int l, input int s);
        bus.ff_row_len = (A+1)'(l);
        bus.ff_stride  = 3'(s);
        m_l = l;
        m_s = s;
    endtask

    // Drives one cycle; returns 1 time unit after the rising edge.
    task automatic step(input bit ren, input bit wen, input logic [W-1:0] din);
        bus.ff_ren = ren;
        bus.ff_wen = wen;
        bus.ff_din = din;
        model_edge(ren, wen, din);
        @(posedge clk);
        #1;
        bus.ff_ren = 1'b0;
        bus.ff_wen = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (bus.ff_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", bus.ff_cnt); end
        checks++; if (bus.ff_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b exp 1", bus.ff_empty); end
        checks++; if (bus.ff_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b exp 0", bus.ff_full); end
        checks++; if (bus.ff_load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done: got %b exp 0", bus.ff_load_done); end
        checks++; if ({bus.ff_out2, bus.ff_out1, bus.ff_out0, bus.entry, bus.entry_vld} !== '0) begin
            errors++; $display("FAIL reset_outs: got %h exp 0", {bus.ff_out2, bus.ff_out1, bus.ff_out0, bus.entry, bus.entry_vld});
        end
    endtask

    task automatic test_stride1();
        do_reset();
        set_cfg(8, 1);
        for (int i = 1; i <= 24; i++) step(1'b0, 1'b1, W'(i));
        checks++; if (bus.ff_cnt !== 11'd24) begin errors++; $display("FAIL s1_cnt24: got %0d exp 24", bus.ff_cnt); end
        checks++; if (bus.ff_load_done !== 1'b1 || bus.ff_full !== 1'b0 || bus.ff_empty !== 1'b0) begin
            errors++; $display("FAIL s1_flags: got ld=%b full=%b empty=%b exp 1 0 0", bus.ff_load_done, bus.ff_full, bus.ff_empty);
        end
        step(1'b1, 1'b0, '0);
        checks++; if (bus.ff_out2 !== {8'd3, 8'd2, 8'd1}) begin errors++; $display("FAIL s1_w1_top: got %h exp 030201", bus.ff_out2); end
        checks++; if (bus.ff_out1 !== {8'd11, 8'd10, 8'd9}) begin errors++; $display("FAIL s1_w1_mid: got %h exp 0b0a09", bus.ff_out1); end
        checks++; if (bus.ff_out0 !== {8'd19, 8'd18, 8'd17}) begin errors++; $display("FAIL s1_w1_bot: got %h exp 131211", bus.ff_out0); end
        checks++; if (bus.entry !== 8'd10 || bus.entry_vld !== 1'b1) begin errors++; $display("FAIL s1_w1_entry: got %0d vld=%b exp 10 vld=1", bus.entry, bus.entry_vld); end
        checks++; if (bus.ff_cnt !== 11'd23) begin errors++; $display("FAIL s1_cnt23: got %0d exp 23", bus.ff_cnt); end
        step(1'b0, 1'b0, '0);
        checks++; if (bus.entry_vld !== 1'b0) begin errors++; $display("FAIL s1_vld_pulse: got %b exp 0", bus.entry_vld); end
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0);
        checks++; if (bus.ff_out2 !== {8'd8, 8'd7, 8'd6} || bus.entry !== 8'd15) begin
            errors++; $display("FAIL s1_w6: got top=%h entry=%0d exp 080706 15", bus.ff_out2, bus.entry);
        end
        checks++; if (bus.ff_cnt !== 11'd16 || bus.ff_load_done !== 1'b0) begin
            errors++; $display("FAIL s1_row_jump: got cnt=%0d ld=%b exp 16 0", bus.ff_cnt, bus.ff_load_done);
        end
        step(1'b1, 1'b0, '0);
        checks++; if (bus.entry_vld !== 1'b0 || bus.ff_out2 !== {8'd8, 8'd7, 8'd6} || bus.ff_cnt !== 11'd16) begin
            errors++; $display("FAIL s1_ignored_read: got vld=%b top=%h cnt=%0d exp 0 080706 16", bus.entry_vld, bus.ff_out2, bus.ff_cnt);
        end
        for (int i = 25; i <= 32; i++) step(1'b0, 1'b1, W'(i));
        checks++; if (bus.ff_cnt !== 11'd24 || bus.ff_load_done !== 1'b1) begin
            errors++; $display("FAIL s1_refill: got cnt=%0d ld=%b exp 24 1", bus.ff_cnt, bus.ff_load_done);
        end
        step(1'b1, 1'b0, '0);
        checks++; if ({bus.ff_out2, bus.ff_out1, bus.ff_out0} !== {8'd11, 8'd10, 8'd9, 8'd19, 8'd18, 8'd17, 8'd27, 8'd26, 8'd25}
                      || bus.entry !== 8'd18) begin
            errors++; $display("FAIL s1_row2: got %h entry=%0d exp 0b0a091312111b1a19 18", {bus.ff_out2, bus.ff_out1, bus.ff_out0}, bus.entry);
        end
    endtask

    task automatic test_stride2();
        logic [3*W-1:0] exp_top [3];
        exp_top[0] = {8'd3, 8'd2, 8'd1};
        exp_top[1] = {8'd5, 8'd4, 8'd3};
        exp_top[2] = {8'd7, 8'd6, 8'd5};
        do_reset();
        set_cfg(8, 2);
        for (int i = 1; i <= 24; i++) step(1'b0, 1'b1, W'(i));
        for (int r = 0; r < 3; r++) begin
            step(1'b1, 1'b0, '0);
            checks++; if (bus.ff_out2 !== exp_top[r] || bus.entry_vld !== 1'b1) begin
                errors++; $display("FAIL s2_top%0d: got %h vld=%b exp %h vld=1", r, bus.ff_out2, bus.entry_vld, exp_top[r]);
            end
        end
        checks++; if (bus.ff_cnt !== 11'd16) begin errors++; $display("FAIL s2_cnt: got %0d exp 16", bus.ff_cnt); end
    endtask

    task automatic test_full();
        do_reset();
        set_cfg(8, 1);
        for (int i = 1; i <= D + 1; i++) step(1'b0, 1'b1, W'(i));
        checks++; if (bus.ff_cnt !== 11'(D) || bus.ff_full !== 1'b1 || bus.ff_empty !== 1'b0) begin
            errors++; $display("FAIL full_cnt: got cnt=%0d full=%b empty=%b exp %0d 1 0", bus.ff_cnt, bus.ff_full, bus.ff_empty, D);
        end
        // A read and a write at full: the read frees space but the write is
        // judged on the pre-edge count, so it is dropped.
        step(1'b1, 1'b1, 8'hAA);
        checks++; if (bus.ff_cnt !== 11'(D - 1) || bus.ff_out2 !== {8'd3, 8'd2, 8'd1}) begin
            errors++; $display("FAIL full_rw: got cnt=%0d top=%h exp %0d 030201", bus.ff_cnt, bus.ff_out2, D - 1);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_cfg(4, 1);
        for (int i = 1; i <= 14; i++) step(1'b0, 1'b1, W'(i + 100));
        step(1'b1, 1'b1, 8'h55);
        #2;
        rst = 1'b0;
        #1;
        checks++; if ({bus.ff_out2, bus.ff_out1, bus.ff_out0, bus.entry, bus.entry_vld} !== '0) begin
            errors++; $display("FAIL async_outs: got %h exp 0", {bus.ff_out2, bus.ff_out1, bus.ff_out0, bus.entry, bus.entry_vld});
        end
        checks++; if (bus.ff_empty !== 1'b1 || bus.ff_cnt !== '0 || bus.ff_load_done !== 1'b0) begin
            errors++; $display("FAIL async_flags: got empty=%b cnt=%0d ld=%b exp 1 0 0", bus.ff_empty, bus.ff_cnt, bus.ff_load_done);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_back_to_back();
        for (int cfg = 0; cfg < 4; cfg++) begin
            do_reset();
            set_cfg($urandom_range(3, 20), $urandom_range(0, 7));
            for (int c = 0; c < 400; c++) begin
                step($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 65, W'($urandom));
                checks++; if (bus.ff_cnt !== 11'(exp_q.size())) begin
                    errors++; $display("FAIL rnd_cnt cfg%0d cyc%0d: got %0d exp %0d", cfg, c, bus.ff_cnt, exp_q.size());
                end
                checks++; if (bus.ff_load_done !== (exp_q.size() >= 2*m_l + 3) || bus.ff_full !== (exp_q.size() == D)
                              || bus.ff_empty !== (exp_q.size() == 0)) begin
                    errors++; $display("FAIL rnd_flags cfg%0d cyc%0d: got ld=%b full=%b empty=%b size=%0d", cfg, c,
                                       bus.ff_load_done, bus.ff_full, bus.ff_empty, exp_q.size());
                end
                checks++; if (bus.entry_vld !== m_vld || bus.entry !== m_entry) begin
                    errors++; $display("FAIL rnd_entry cfg%0d cyc%0d: got %h vld=%b exp %h vld=%b", cfg, c, bus.entry, bus.entry_vld, m_entry, m_vld);
                end
                checks++; if ({bus.ff_out2, bus.ff_out1, bus.ff_out0} !== {m_out2, m_out1, m_out0}) begin
                    errors++; $display("FAIL rnd_window cfg%0d cyc%0d: got %h exp %h", cfg, c,
                                       {bus.ff_out2, bus.ff_out1, bus.ff_out0}, {m_out2, m_out1, m_out0});
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.ff_ren     = 1'b0;
        bus.ff_wen     = 1'b0;
        bus.ff_din     = '0;
        bus.ff_row_len = 11'd8;
        bus.ff_stride  = 3'd1;
        m_l = 8;
        m_s = 1;
        model_reset();
        test_reset();
        test_stride1();
        test_stride2();
        test_full();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/convo_fifo_pmul.md
Name: convo_fifo_pmul

Overview:
- Raster-order pixel FIFO that feeds a 3x3 convolution engine.
- Pixels are written one per cycle.
- Each accepted read presents a 3x3 window (three rows of three pixels) and then advances the window by the stride, skipping to the next row at the end of a row.
- The window centre pixel is also output as a single entry for the pointwise-multiply path.

Parameters:
- FF_WIDTH, 8, pixel width in bits.
- FF_ADDR_BIT, 10, address width; FIFO depth D = 2^FF_ADDR_BIT.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ff_ren  in  1  read (window advance) strobe.
- ff_wen  in  1  write strobe.
- ff_row_len  in  FF_ADDR_BIT+1  row length L in pixels; static while data is held.
- ff_stride  in  3  horizontal stride S; 0 is treated as 1.
- ff_din  in  FF_WIDTH  write pixel.
- ff_out2  out  3*FF_WIDTH  window top row.
- ff_out1  out  3*FF_WIDTH  window middle row.
- ff_out0  out  3*FF_WIDTH  window bottom row.
- ff_load_done  out  1  a full window is available.
- ff_empty  out  1  cnt == 0.
- ff_full  out  1  cnt == D.
- ff_cnt  out  FF_ADDR_BIT+1  number of stored pixels.
- entry  out  FF_WIDTH  window centre pixel.
- entry_vld  out  1  one-cycle pulse marking an updated window/entry.

Behaviour:
- Storage: D-entry register array. Write pointer wp, head pointer hp (both FF_ADDR_BIT bits, wrap modulo D), counter cnt, column register col (position of hp within its row).
- Reset (rst=0, asynchronous): wp=hp=cnt=col=0; all ff_out* = 0; entry = 0; entry_vld = 0. ff_empty=1, ff_full=0, ff_load_done=0.
- Write: accepted when ff_wen=1 and cnt<D. Then mem[wp]=ff_din and wp++. A write while full is ignored; no state changes.
- Window taps relative to hp:
  - top row = mem[hp+0..2]
  - middle row = mem[hp+L+0..2]
  - bottom row = mem[hp+2L+0..2]
  - all addresses taken modulo D.
- Row packing: in each ff_outK, bits [FF_WIDTH-1:0] hold the leftmost column, the next slice column 1, and the top slice column 2.
- ff_load_done is combinational: (cnt >= 2L+3).
- Read: accepted when ff_ren=1 and ff_load_done=1. On the same clock edge:
  - ff_out2/1/0 register the window at the current hp.
  - entry registers mem[hp+L+1].
  - entry_vld is set to 1.
  - The pop amount P is computed: if col+S+3 <= L then P=S and col+=S; otherwise P=L-col and col=0 (jump to next row start).
  - hp += P.
  - Latency is one cycle: outputs are valid the cycle after the strobe edge.
- A read while !ff_load_done is ignored: outputs hold and entry_vld=0.
- entry_vld is 0 in every cycle that did not follow an accepted read.
- Simultaneous read and write: both take effect; cnt_next = cnt + (write accepted) - P. Read acceptance uses the pre-edge cnt; a same-cycle write does not enable a read.
- Windows per row = floor((L-3)/S)+1, with valid (no-padding) semantics.
- Valid configuration is 3 <= L and 2L+3 <= D. Behaviour outside this range is unspecified but must not corrupt cnt.
- ff_empty, ff_full and ff_cnt are combinational from cnt.

Test Plan:
- Reset, then L=8, S=1; write 1..24 on consecutive cycles -> ff_cnt=24, ff_load_done=1, ff_full=0, ff_empty=0.
- First read -> next cycle: ff_out2 slices (low to high) 1,2,3; ff_out1 9,10,11; ff_out0 17,18,19; entry=10, entry_vld=1 for one cycle; ff_cnt=23.
- Five more reads -> 6th window top row 6,7,8 and entry=15. After it hp jumps to pixel 9, ff_cnt=16, ff_load_done=0. A 7th read is ignored: outputs hold, entry_vld=0.
- Write 25..32 -> ff_cnt=24, ff_load_done=1; next read gives top row 9,10,11, middle 17,18,19, bottom 25,26,27, entry=18.
- L=8, S=2 with 24 pixels -> windows at top-row starts 1,3,5. After the third read ff_cnt=16 (pops 2,2,4).
- Write D+1 pixels with reads off -> ff_cnt=D, ff_full=1, last write dropped. Assert rst low mid-stream -> all outputs zero immediately, ff_empty=1.
